// File: rtl/avst_pkt_arbiter_if.sv
// avst_pkt_arbiter_if: bundles the NUM_SRC Avalon-ST source streams and the
// single arbitrated output stream around avst_pkt_arbiter.
//   in_data/in_sop/in_eop/in_empty/in_valid  per-source stream, driven by sources
//   in_ready                                 per-source ready, driven by the arbiter
//   out_data/out_sop/out_eop/out_empty/out_valid  arbitrated stream, driven by the arbiter
//   out_ready                                downstream ready
// Modports: slave = the arbiter, master = the surrounding sources/sink.
interface avst_pkt_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [NUM_SRC-1:0][DATA_W-1:0]  in_data;
  logic [NUM_SRC-1:0][EMPTY_W-1:0] in_empty;
  logic [NUM_SRC-1:0]              in_sop;
  logic [NUM_SRC-1:0]              in_eop;
  logic [NUM_SRC-1:0]              in_valid;
  logic [NUM_SRC-1:0]              in_ready;

  logic [DATA_W-1:0]               out_data;
  logic [EMPTY_W-1:0]              out_empty;
  logic                            out_sop;
  logic                            out_eop;
  logic                            out_valid;
  logic                            out_ready;

  modport slave (
    input  in_data, in_empty, in_sop, in_eop, in_valid,
    output in_ready,
    output out_data, out_empty, out_sop, out_eop, out_valid,
    input  out_ready
  );

  modport master (
    output in_data, in_empty, in_sop, in_eop, in_valid,
    input  in_ready,
    input  out_data, out_empty, out_sop, out_eop, out_valid,
    output out_ready
  );
endinterface

// File: rtl/avst_pkt_arbiter.sv
// avst_pkt_arbiter: packet-atomic round-robin arbiter sharing one Avalon-ST
// sink between NUM_SRC packet sources. The grant is held from sop to eop,
// orphan beats (valid without sop while idle) are discarded, and packets
// longer than MAX_BEATS are cut with a forced eop.
// Ports:
//   sys_clk    system clock, rising edge
//   reset_n    async active-low reset
//   st         avst_pkt_arbiter_if.slave (source streams in, arbitrated stream out)
//   grant_idx  current / last granted source
//   busy       high while a packet is in flight
//   drop_cnt   orphan beats discarded (saturating)
//   trunc_cnt  packets force-terminated (saturating)
//
//   state | meaning
//   IDLE  | nothing in flight; pick next sop requester, discard orphan beats
//   XFER  | granted source passed through to out until eop or forced eop
module avst_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(NUM_SRC),
  localparam int BEAT_W   = $clog2(MAX_BEATS),
  localparam int INC_W    = $clog2(NUM_SRC + 1)
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  avst_pkt_arbiter_if.slave st,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  trunc_cnt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   grant_nx, rr_last, rr_last_nx, cand;
  logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nx;
  logic [NUM_SRC-1:0] ready_c;
  logic [INC_W-1:0]   drop_inc;
  logic               trunc_inc, found, force_eop, beat_acc;
  logic [CNT_W:0]     drop_sum, trunc_sum;

  // Last allowed beat without a source eop gets terminated here.
  assign force_eop = (state == XFER) && (beat_cnt == BEAT_W'(MAX_BEATS - 1)) &&
                     !st.in_eop[grant_idx];
  assign beat_acc  = (state == XFER) && st.in_valid[grant_idx] && st.out_ready;

  // Pure combinational pass-through of the granted source; no datapath register.
  assign st.out_data  = st.in_data[grant_idx];
  assign st.out_sop   = st.in_sop[grant_idx];
  assign st.out_eop   = st.in_eop[grant_idx] | force_eop;
  assign st.out_empty = force_eop ? '0 : st.in_empty[grant_idx];
  assign st.out_valid = (state == XFER) && st.in_valid[grant_idx];

  // Ready is held low while in reset so no source sees a handshake then.
  assign st.in_ready = reset_n ? ready_c : '0;
  assign busy        = (state == XFER);

  always_comb begin
    state_nx    = state;
    grant_nx    = grant_idx;
    rr_last_nx  = rr_last;
    beat_cnt_nx = beat_cnt;
    ready_c     = '0;
    drop_inc    = '0;
    trunc_inc   = 1'b0;
    found       = 1'b0;
    cand        = '0;
    unique case (state)
      IDLE: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (st.in_valid[i] && !st.in_sop[i]) begin
            ready_c[i] = 1'b1;
            drop_inc   = drop_inc + INC_W'(1);
          end
        end
        // Search starts just after the last winner so every source gets a turn.
        for (int k = 1; k <= NUM_SRC; k++) begin
          cand = IDX_W'((int'(rr_last) + k) % NUM_SRC);
          if (!found && st.in_valid[cand] && st.in_sop[cand]) begin
            found    = 1'b1;
            grant_nx = cand;
          end
        end
        if (found) begin
          rr_last_nx  = grant_nx;
          beat_cnt_nx = '0;
          state_nx    = XFER;
        end
      end
      XFER: begin
        ready_c[grant_idx] = st.out_ready;
        if (beat_acc) begin
          if (st.in_eop[grant_idx] || force_eop) begin
            trunc_inc = force_eop;
            state_nx  = IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + BEAT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_inc);
  assign trunc_sum = {1'b0, trunc_cnt} + (CNT_W + 1)'(trunc_inc);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_last   <= IDX_W'(NUM_SRC - 1);
      beat_cnt  <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_nx;
      rr_last   <= rr_last_nx;
      beat_cnt  <= beat_cnt_nx;
      drop_cnt  <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      trunc_cnt <= trunc_sum[CNT_W] ? {CNT_W{1'b1}} : trunc_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
module tb_avst_pkt_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 8;
  localparam int DATA_W    = 16;
  localparam int EMPTY_W   = 2;

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt, trunc_cnt;
  int errors = 0;
  int checks = 0;

  avst_pkt_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) bus ();

  avst_pkt_arbiter #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .st(bus.slave),
    .grant_idx(grant_idx), .busy(busy), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [DATA_W-1:0] mk(input int src, input int pkt, input int beat);
    return {4'(src), 4'(pkt), 8'(beat)};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.in_valid  = '0;
    bus.in_sop    = '0;
    bus.in_eop    = '0;
    bus.in_data   = '0;
    bus.in_empty  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic set_src(input int i, input logic v, input logic s, input logic e,
                         input logic [DATA_W-1:0] d, input logic [EMPTY_W-1:0] em);
    bus.in_valid[i] = v;
    bus.in_sop[i]   = s;
    bus.in_eop[i]   = e;
    bus.in_data[i]  = d;
    bus.in_empty[i] = em;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_inputs();
    set_src(0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0), 2'd0);
    set_src(1, 1'b1, 1'b1, 1'b0, mk(1, 0, 0), 2'd0);
    reset_n = 1'b0;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", bus.in_ready); end
    tick();
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (trunc_cnt !== 8'd0) begin errors++; $display("FAIL rst_trunc_cnt: got %0d want 0", trunc_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_held: got %b want 0", busy); end
    clr_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int ptr = 0;
    int busy_cycles = 0;
    logic hs;
    do_reset();
    set_src(1, 1'b1, 1'b1, 1'b0, mk(1, 0, 0), 2'd0);
    #1;
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_grant_cycle: busy=%b valid=%b want 0 0", busy, bus.out_valid); end
    checks++; if (bus.in_ready[1] !== 1'b0) begin errors++; $display("FAIL single_grant_ready: got %b want 0", bus.in_ready[1]); end
    tick();
    for (int c = 0; c < 10 && ptr < 3; c++) begin
      set_src(1, 1'b1, ptr == 0, ptr == 2, mk(1, 0, ptr), 2'd0);
      #1;
      if (busy) busy_cycles++;
      checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d want 1", grant_idx); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(1, 0, ptr)) begin errors++; $display("FAIL single_beat%0d: valid=%b data=%h want 1 %h", ptr, bus.out_valid, bus.out_data, mk(1, 0, ptr)); end
      checks++; if (bus.out_sop !== (ptr == 0) || bus.out_eop !== (ptr == 2)) begin errors++; $display("FAIL single_flags%0d: sop=%b eop=%b", ptr, bus.out_sop, bus.out_eop); end
      hs = bus.in_valid[1] & bus.in_ready[1];
      tick();
      if (hs) ptr++;
    end
    clr_inputs();
    #1;
    checks++; if (ptr !== 3) begin errors++; $display("FAIL single_beats_done: got %0d want 3", ptr); end
    checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL single_busy_cycles: got %0d want 3", busy_cycles); end
    checks++; if (busy !== 1'b0 || grant_idx !== 2'd1) begin errors++; $display("FAIL single_after: busy=%b grant=%0d want 0 1", busy, grant_idx); end
  endtask

  task automatic test_fairness();
    int ptr[NUM_SRC];
    int pkt[NUM_SRC];
    logic hs[NUM_SRC];
    int npk = 0;
    int exp_src = 0;
    int cur = 0;
    int last = -1;
    logic busy_q = 1'b0;
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin ptr[i] = 0; pkt[i] = 0; end
    for (int c = 0; c < 40 && npk < 8; c++) begin
      for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, ptr[i] == 0, ptr[i] == 1, mk(i, pkt[i], ptr[i]), 2'd0);
      #1;
      if (busy && !busy_q) begin
        checks++; if (grant_idx !== 2'(exp_src)) begin errors++; $display("FAIL fair_order%0d: got %0d want %0d", npk, grant_idx, exp_src); end
        if (last >= 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL fair_period%0d: got %0d want 3", npk, c - last); end
        end
        cur = exp_src;
        exp_src = (exp_src + 1) % NUM_SRC;
        last = c;
        npk++;
      end
      if (busy) begin
        checks++; if (bus.out_data !== mk(cur, pkt[cur], ptr[cur])) begin errors++; $display("FAIL fair_data: got %h want %h", bus.out_data, mk(cur, pkt[cur], ptr[cur])); end
      end
      busy_q = busy;
      for (int i = 0; i < NUM_SRC; i++) hs[i] = bus.in_valid[i] & bus.in_ready[i];
      tick();
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hs[i]) begin
          if (ptr[i] == 1) begin ptr[i] = 0; pkt[i]++; end else ptr[i] = 1;
        end
      end
    end
    checks++; if (npk !== 8) begin errors++; $display("FAIL fair_pkts: got %0d want 8", npk); end
    clr_inputs();
  endtask

  task automatic test_backpressure();
    int ptr = 0;
    logic hs;
    logic [DATA_W-1:0] got[$];
    do_reset();
    for (int c = 0; c < 20 && ptr < 4; c++) begin
      set_src(3, 1'b1, ptr == 0, ptr == 3, mk(3, 0, ptr), 2'd0);
      bus.out_ready = !(c >= 2 && c <= 4);
      #1;
      if (c >= 1) begin
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd3) begin errors++; $display("FAIL bp_grant_c%0d: busy=%b grant=%0d want 1 3", c, busy, grant_idx); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== mk(3, 0, ptr)) begin errors++; $display("FAIL bp_data_c%0d: data=%h want %h", c, bus.out_data, mk(3, 0, ptr)); end
        checks++; if (bus.in_ready[3] !== bus.out_ready) begin errors++; $display("FAIL bp_ready_c%0d: got %b want %b", c, bus.in_ready[3], bus.out_ready); end
      end
      hs = bus.out_valid & bus.out_ready;
      if (hs) got.push_back(bus.out_data);
      tick();
      if (bus.in_valid[3] && hs) ptr++;
    end
    clr_inputs();
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++; if (got[k] !== mk(3, 0, k)) begin errors++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], mk(3, 0, k)); end
    end
  endtask

  task automatic test_orphans();
    do_reset();
    set_src(2, 1'b1, 1'b0, 1'b0, mk(2, 0, 0), 2'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.in_ready[2] !== 1'b1) begin errors++; $display("FAIL orph_ready_c%0d: got %b want 1", c, bus.in_ready[2]); end
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL orph_valid_c%0d: valid=%b busy=%b want 0 0", c, bus.out_valid, busy); end
      tick();
    end
    clr_inputs();
    #1;
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL orph_drop5: got %0d want 5", drop_cnt); end
    set_src(0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0), 2'd0);
    set_src(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 0), 2'd0);
    tick();
    clr_inputs();
    #1;
    checks++; if (drop_cnt !== 8'd7) begin errors++; $display("FAIL orph_drop_multi: got %0d want 7", drop_cnt); end
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 1'b0, 1'b0, mk(i, 0, 0), 2'd0);
    repeat (70) tick();
    clr_inputs();
    #1;
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL orph_saturate: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_runaway();
    int ptr0 = 0;
    int ptr1 = 0;
    int acc0 = 0;
    logic hs0, hs1;
    do_reset();
    for (int c = 0; c < 40 && ptr1 < 2; c++) begin
      if (ptr0 < 12) set_src(0, 1'b1, ptr0 == 0, ptr0 == 11, mk(0, 0, ptr0), 2'd3);
      else           set_src(0, 1'b0, 1'b0, 1'b0, '0, 2'd0);
      if (ptr0 == 12) set_src(1, 1'b1, ptr1 == 0, ptr1 == 1, mk(1, 0, ptr1), 2'd0);
      else            set_src(1, 1'b0, 1'b0, 1'b0, '0, 2'd0);
      #1;
      if (bus.out_valid && bus.out_ready && ptr0 < 12) begin
        acc0++;
        checks++; if (bus.out_data !== mk(0, 0, ptr0)) begin errors++; $display("FAIL run_data%0d: got %h want %h", ptr0, bus.out_data, mk(0, 0, ptr0)); end
        checks++; if (bus.out_eop !== (acc0 == 8)) begin errors++; $display("FAIL run_eop_beat%0d: got %b want %b", acc0, bus.out_eop, acc0 == 8); end
        if (acc0 == 8) begin
          checks++; if (bus.out_empty !== 2'd0) begin errors++; $display("FAIL run_empty: got %0d want 0", bus.out_empty); end
        end
      end
      if (bus.out_valid && bus.out_ready && ptr0 == 12) begin
        checks++; if (grant_idx !== 2'd1 || bus.out_data !== mk(1, 0, ptr1)) begin errors++; $display("FAIL run_src1: grant=%0d data=%h want 1 %h", grant_idx, bus.out_data, mk(1, 0, ptr1)); end
      end
      hs0 = bus.in_valid[0] & bus.in_ready[0];
      hs1 = bus.in_valid[1] & bus.in_ready[1];
      tick();
      if (hs0) ptr0++;
      if (hs1) ptr1++;
    end
    clr_inputs();
    #1;
    checks++; if (acc0 !== 8) begin errors++; $display("FAIL run_out_beats: got %0d want 8", acc0); end
    checks++; if (trunc_cnt !== 8'd1) begin errors++; $display("FAIL run_trunc_cnt: got %0d want 1", trunc_cnt); end
    checks++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL run_drop_cnt: got %0d want 4", drop_cnt); end
    checks++; if (ptr1 !== 2) begin errors++; $display("FAIL run_src1_done: got %0d want 2", ptr1); end
  endtask

  task automatic test_reset_mid();
    int ptr = 0;
    logic hs;
    do_reset();
    set_src(2, 1'b1, 1'b0, 1'b0, mk(2, 0, 0), 2'd0);
    tick();
    clr_inputs();
    for (int c = 0; c < 10 && ptr < 2; c++) begin
      set_src(1, 1'b1, ptr == 0, 1'b0, mk(1, 0, ptr), 2'd0);
      #1;
      hs = bus.in_valid[1] & bus.in_ready[1];
      tick();
      if (hs) ptr++;
    end
    set_src(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 2), 2'd0);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL mid_before: valid=%b drop=%0d want 1 1", bus.out_valid, drop_cnt); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abort: valid=%b busy=%b want 0 0", bus.out_valid, busy); end
    checks++; if (drop_cnt !== 8'd0 || trunc_cnt !== 8'd0) begin errors++; $display("FAIL mid_counters: drop=%0d trunc=%0d want 0 0", drop_cnt, trunc_cnt); end
    checks++; if (grant_idx !== 2'd0 || bus.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_grant: grant=%0d ready=%b want 0 0000", grant_idx, bus.in_ready); end
    clr_inputs();
    tick();
    reset_n = 1'b1;
    set_src(0, 1'b1, 1'b1, 1'b1, mk(0, 1, 0), 2'd0);
    set_src(2, 1'b1, 1'b1, 1'b1, mk(2, 1, 0), 2'd0);
    tick();
    checks++; if (busy !== 1'b1 || grant_idx !== 2'd0 || bus.out_data !== mk(0, 1, 0)) begin errors++; $display("FAIL mid_first_winner: busy=%b grant=%0d data=%h want 1 0 %h", busy, grant_idx, bus.out_data, mk(0, 1, 0)); end
    clr_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    clr_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_orphans();
    test_runaway();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
